// File: rtl/imem_loader_pkg.sv
// Shared types and defaults for the UART instruction-memory boot loader.
package imem_loader_pkg;

    localparam int unsigned DefAddrW = 8;
    localparam logic [7:0]  DefSync  = 8'hA5;

    typedef enum logic [2:0] {
        StIdle,
        StCntH,
        StCntL,
        StData,
        StChk,
        StDone,
        StErr
    } state_e;

endpackage

// File: rtl/imem_loader.sv
// Boot loader: parses SYNC/CNT/data/CHK frames from the UART and writes big-endian packed
// words into instruction RAM, holding the CPU in reset until a verified image is present.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter logic [7:0]  SYNC   = DefSync
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] WordOne = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [31:0]     MaxWords = 32'd1 << ADDR_W;

    state_e            state_q, state_d;
    logic [7:0]        cnt_hi_q, cnt_hi_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   word_idx_q, word_idx_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       pack_q, pack_d;
    logic [7:0]        chk_q, chk_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [31:0]       cnt_full;

    always_comb begin
        state_d    = state_q;
        cnt_hi_d   = cnt_hi_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        pack_d     = pack_q;
        chk_d      = chk_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        hold_d     = hold_q;
        done_d     = done_q;
        err_d      = err_q;
        cnt_full   = {16'h0000, cnt_hi_q, rx_data};

        if (rx_valid) begin
            case (state_q)
                StIdle, StErr: begin
                    if (rx_data == SYNC) begin
                        err_d   = 1'b0;
                        chk_d   = 8'h00;
                        state_d = StCntH;
                    end
                end
                StCntH: begin
                    cnt_hi_d = rx_data;
                    chk_d    = rx_data;
                    state_d  = StCntL;
                end
                StCntL: begin
                    chk_d = chk_q ^ rx_data;
                    if (cnt_full == 32'd0 || cnt_full > MaxWords) begin
                        err_d   = 1'b1;
                        state_d = StErr;
                    end else begin
                        count_d    = cnt_full[ADDR_W:0];
                        word_idx_d = '0;
                        byte_idx_d = 2'd0;
                        pack_d     = 32'h0;
                        state_d    = StData;
                    end
                end
                StData: begin
                    chk_d      = chk_q ^ rx_data;
                    pack_d     = {pack_q[23:0], rx_data};
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        we_d       = 1'b1;
                        addr_d     = word_idx_q[ADDR_W-1:0];
                        wdata_d    = {pack_q[23:0], rx_data};
                        word_idx_d = word_idx_q + WordOne;
                        if (word_idx_q + WordOne == count_q) begin
                            state_d = StChk;
                        end
                    end
                end
                StChk: begin
                    if (rx_data == chk_q) begin
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                        state_d = StDone;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StErr;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_hi_q   <= 8'h00;
            count_q    <= '0;
            word_idx_q <= '0;
            byte_idx_q <= 2'd0;
            pack_q     <= 32'h0;
            chk_q      <= 8'h00;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            hold_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_hi_q   <= cnt_hi_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            pack_q     <= pack_d;
            chk_q      <= chk_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_hold   = hold_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomised frame-level bench for imem_loader: a frame model predicts RAM writes into a
// scoreboard queue that a negedge monitor drains, and status outputs are checked per frame.
`timescale 1ns/1ps
module tb_imem_loader;

    localparam logic [7:0] SYNC = 8'hA5;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    imem_loader #(.ADDR_W(8), .SYNC(SYNC)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] words[256];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_writes = 0;
    logic [7:0]  last_addr = 8'h00;
    bit          exp_done, exp_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Scoreboard monitor: every write strobe must match the oldest predicted write.
    always @(negedge clk) begin
        if (!reset && imem_we) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                check("unexpected imem_we", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("imem_addr", {24'h0, imem_addr}, {24'h0, e.addr});
                check("imem_wdata", imem_wdata, e.data);
                last_addr = imem_addr;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    function automatic int pick_gap(input bit b2b);
        return b2b ? 0 : int'($urandom_range(0, 2));
    endfunction

    // Drive one byte for one cycle, then idle for gap cycles (inputs change at posedge+1).
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_data  = $urandom();
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, " done"}, {31'h0, done}, {31'h0, exp_done});
        check({tag, " err"}, {31'h0, err}, {31'h0, exp_err});
        check({tag, " cpu_hold"}, {31'h0, cpu_hold}, {31'h0, !exp_done});
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " imem_we"}, {31'h0, imem_we}, 32'd0);
        check({tag, " imem_addr"}, {24'h0, imem_addr}, 32'd0);
        check({tag, " imem_wdata"}, imem_wdata, 32'd0);
        check({tag, " cpu_hold"}, {31'h0, cpu_hold}, 32'd1);
        check({tag, " done"}, {31'h0, done}, 32'd0);
        check({tag, " err"}, {31'h0, err}, 32'd0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        check_reset_values(tag);
        @(posedge clk); #1;
        reset    = 1'b0;
        exp_done = 1'b0;
        exp_err  = 1'b0;
    endtask

    task automatic drain(input string tag);
        repeat (2) begin
            @(posedge clk); #1;
        end
        check({tag, " writes outstanding"}, exp_q.size(), 32'd0);
    endtask

    task automatic fill_words(input int n);
        for (int i = 0; i < n; i++) words[i] = $urandom();
    endtask

    // Sends a whole frame and predicts its effect: a valid count writes words 0..cnt-1,
    // and the image is accepted only when the checksum byte matches.
    task automatic send_frame(input logic [15:0] cnt, input bit bad, input bit b2b,
                              input string tag);
        logic [7:0] x;
        logic [7:0] b;
        bit         ok;
        ok = (cnt != 16'd0) && (cnt <= 16'd256);
        x  = cnt[15:8] ^ cnt[7:0];
        send_byte(SYNC, pick_gap(b2b));
        send_byte(cnt[15:8], pick_gap(b2b));
        if (!ok) begin
            send_byte(cnt[7:0], 0);
            exp_done = 1'b0;
            exp_err  = 1'b1;
            check_status(tag);
            return;
        end
        send_byte(cnt[7:0], pick_gap(b2b));
        for (int i = 0; i < int'(cnt); i++) begin
            wr_t e;
            e.addr = i[7:0];
            e.data = words[i];
            exp_q.push_back(e);
            for (int k = 3; k >= 0; k--) begin
                b = words[i][k*8 +: 8];
                x = x ^ b;
                send_byte(b, pick_gap(b2b));
            end
        end
        send_byte(bad ? (x ^ 8'h5A) : x, 0);
        exp_done = !bad;
        exp_err  = bad;
        check_status(tag);
    endtask

    initial begin
        logic [7:0]  addr_before;
        logic [31:0] wdata_before;
        int          writes_before;

        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("power-up");
        reset = 1'b0;
        @(posedge clk); #1;

        // Single-word frame A5 00 01 08 00 00 02 0B.
        words[0] = 32'h08000002;
        send_frame(16'd1, 1'b0, 1'b0, "single");
        drain("single");

        // Three words, rx_valid on consecutive cycles.
        do_reset("reset2");
        fill_words(3);
        send_frame(16'd3, 1'b0, 1'b1, "b2b");
        drain("b2b");

        // Bad checksum, then the same frame resent correctly.
        do_reset("reset3");
        fill_words(3);
        send_frame(16'd3, 1'b1, 1'b0, "badchk");
        drain("badchk");
        send_frame(16'd3, 1'b0, 1'b0, "resend");
        drain("resend");

        // Count boundaries: 0 and 257 rejected, 256 accepted.
        do_reset("reset4");
        send_frame(16'h0000, 1'b0, 1'b0, "cnt0");
        send_frame(16'h0101, 1'b0, 1'b0, "cnt257");
        drain("cntbad");
        fill_words(256);
        send_frame(16'h0100, 1'b0, 1'b0, "cnt256");
        drain("cnt256");
        check("cnt256 last addr", {24'h0, last_addr}, 32'h0000_00FF);

        // Reset after byte 2 of word 1.
        do_reset("reset5");
        fill_words(3);
        begin
            wr_t e;
            e.addr = 8'h00;
            e.data = words[0];
            exp_q.push_back(e);
        end
        send_byte(SYNC, 0);
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        for (int k = 3; k >= 0; k--) send_byte(words[0][k*8 +: 8], pick_gap(1'b0));
        send_byte(words[1][31:24], 0);
        send_byte(words[1][23:16], 0);
        drain("partial");
        do_reset("midframe");
        fill_words(1 + int'($urandom_range(0, 7)));
        send_frame(16'(1 + $urandom_range(0, 7)), 1'b0, 1'b0, "after-reset");
        drain("after-reset");

        // Leading garbage, then bytes after done.
        do_reset("reset6");
        send_byte(8'h00, 0);
        send_byte(8'hFF, 1);
        send_byte(8'h12, 0);
        fill_words(4);
        send_frame(16'd4, 1'b0, 1'b0, "garbage");
        drain("garbage");
        addr_before   = imem_addr;
        wdata_before  = imem_wdata;
        writes_before = n_writes;
        send_byte(SYNC, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        for (int i = 0; i < 6; i++) send_byte($urandom(), pick_gap(1'b0));
        drain("post-done");
        check_status("post-done");
        check("post-done writes", n_writes - writes_before, 32'd0);
        check("post-done addr", {24'h0, imem_addr}, {24'h0, addr_before});
        check("post-done wdata", imem_wdata, wdata_before);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
